// File: rtl/sys_ctrl_cmd_sequencer.sv
// sys_ctrl_cmd_sequencer: decodes RX byte commands (0xAA wr, 0xBB rd, 0xCC alu+ops, 0xDD alu) into RF/ALU strobes and TX FIFO bytes; REF_CLK/RST, RX_*, RF_*, ALU_*, CLK_GATE_EN, FIFO_FULL, TX_*; optional CMD_TIMEOUT_EN inter-byte timeout
module sys_ctrl_cmd_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     REF_CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_DATA_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]    RF_ADDR,
  output logic                     RF_WR_EN,
  output logic                     RF_RD_EN,
  output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);
  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_ALU_A,
    S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_SEND_RD, S_SEND_LO, S_SEND_HI
  } state_t;
  state_t state;
  logic [ALU_OUT_WIDTH-1:0] result;
`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt;
  logic timed;
  assign timed = state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_A, S_ALU_B, S_ALU_FUN};
`endif
  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      result      <= '0;
      RF_ADDR     <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_WR_DATA  <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
      TX_D_VLD <= 1'b0;
      case (state)
        S_IDLE: if (RX_D_VLD) begin
          state <= RX_P_DATA == DATA_WIDTH'(8'hAA) ? S_WR_ADDR :
                   RX_P_DATA == DATA_WIDTH'(8'hBB) ? S_RD_ADDR :
                   RX_P_DATA == DATA_WIDTH'(8'hCC) ? S_ALU_A   :
                   RX_P_DATA == DATA_WIDTH'(8'hDD) ? S_ALU_FUN : S_IDLE;
          CLK_GATE_EN <= RX_P_DATA == DATA_WIDTH'(8'hDD);
        end
        S_WR_ADDR: if (RX_D_VLD) begin
          RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
          state   <= S_WR_DATA;
        end
        S_WR_DATA: if (RX_D_VLD) begin
          RF_WR_DATA <= RX_P_DATA;
          RF_WR_EN   <= 1'b1;
          state      <= S_IDLE;
        end
        S_RD_ADDR: if (RX_D_VLD) begin
          RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
          RF_RD_EN <= 1'b1;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT: if (RF_RD_DATA_VLD) begin
          result <= ALU_OUT_WIDTH'(RF_RD_DATA);
          state  <= S_SEND_RD;
        end
        S_ALU_A: if (RX_D_VLD) begin
          RF_ADDR    <= '0;
          RF_WR_DATA <= RX_P_DATA;
          RF_WR_EN   <= 1'b1;
          state      <= S_ALU_B;
        end
        S_ALU_B: if (RX_D_VLD) begin
          RF_ADDR     <= ADDR_WIDTH'(1);
          RF_WR_DATA  <= RX_P_DATA;
          RF_WR_EN    <= 1'b1;
          CLK_GATE_EN <= 1'b1;
          state       <= S_ALU_FUN;
        end
        S_ALU_FUN: if (RX_D_VLD) begin
          ALU_FUN <= RX_P_DATA[3:0];
          ALU_EN  <= 1'b1;
          state   <= S_ALU_WAIT;
        end
        S_ALU_WAIT: if (ALU_OUT_VLD) begin
          result      <= ALU_OUT;
          CLK_GATE_EN <= 1'b0;
          state       <= S_SEND_LO;
        end
        S_SEND_RD, S_SEND_LO, S_SEND_HI: if (!FIFO_FULL) begin
          TX_D_VLD  <= 1'b1;
          TX_P_DATA <= state == S_SEND_HI ? DATA_WIDTH'(result >> DATA_WIDTH) : result[DATA_WIDTH-1:0];
          state     <= state == S_SEND_LO ? S_SEND_HI : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef CMD_TIMEOUT_EN
      tmo_cnt <= timed && !RX_D_VLD ? tmo_cnt + 1'b1 : '0;
      if (timed && !RX_D_VLD && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state       <= S_IDLE;
        CLK_GATE_EN <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_sys_ctrl_cmd_sequencer.sv
// tb_sys_ctrl_cmd_sequencer: directed scoreboard bench for sys_ctrl_cmd_sequencer
module tb_sys_ctrl_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_p_data, rf_rd_data;
  logic       rx_d_vld, rf_rd_data_vld, alu_out_vld, fifo_full;
  logic [15:0] alu_out;
  logic [3:0] rf_addr, alu_fun;
  logic       rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_d_vld;
  logic [7:0] rf_wr_data, tx_p_data;
  int passed = 0, total = 0;
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$], alu_q[$];
  logic [7:0]  tx_q[$];
  logic gate_prev = 1'b0;
  always #5 clk = ~clk;
  sys_ctrl_cmd_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .REF_CLK(clk), .RST(rst), .RX_P_DATA(rx_p_data), .RX_D_VLD(rx_d_vld),
    .RF_RD_DATA(rf_rd_data), .RF_RD_DATA_VLD(rf_rd_data_vld), .ALU_OUT(alu_out),
    .ALU_OUT_VLD(alu_out_vld), .FIFO_FULL(fifo_full), .RF_ADDR(rf_addr),
    .RF_WR_EN(rf_wr_en), .RF_RD_EN(rf_rd_en), .RF_WR_DATA(rf_wr_data),
    .ALU_EN(alu_en), .ALU_FUN(alu_fun), .CLK_GATE_EN(clk_gate_en),
    .TX_P_DATA(tx_p_data), .TX_D_VLD(tx_d_vld)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_p_data = b;
    rx_d_vld = 1'b1;
    @(negedge clk);
    rx_d_vld = 1'b0;
  endtask
  task automatic rd_resp(input logic [7:0] d);
    repeat (2) @(negedge clk);
    rf_rd_data = d;
    rf_rd_data_vld = 1'b1;
    @(negedge clk);
    rf_rd_data_vld = 1'b0;
  endtask
  task automatic alu_resp(input logic [15:0] r);
    repeat (2) @(negedge clk);
    alu_out = r;
    alu_out_vld = 1'b1;
    @(negedge clk);
    alu_out_vld = 1'b0;
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (tx_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, tx_q.size(), 0);
  endtask
  always begin
    @(posedge clk);
    #1;
    chk("strobe_excl", 32'($onehot0({rf_wr_en, rf_rd_en, alu_en})), 1);
    if (rf_wr_en) begin
      chk("wr_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) chk("wr_addr_data", {rf_addr, rf_wr_data}, wr_q.pop_front());
    end
    if (rf_rd_en) begin
      chk("rd_expected", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) chk("rd_addr", rf_addr, rd_q.pop_front());
    end
    if (alu_en) begin
      chk("alu_gate_before_en", gate_prev, 1);
      chk("alu_expected", 32'(alu_q.size() != 0), 1);
      if (alu_q.size() != 0) chk("alu_fun", alu_fun, alu_q.pop_front());
    end
    if (tx_d_vld) begin
      chk("tx_while_full", fifo_full, 0);
      chk("tx_expected", 32'(tx_q.size() != 0), 1);
      if (tx_q.size() != 0) chk("tx_byte", tx_p_data, tx_q.pop_front());
    end
    gate_prev = clk_gate_en;
  end
  initial begin
    rst = 1'b1;
    rx_p_data = '0; rx_d_vld = 1'b0; rf_rd_data = '0; rf_rd_data_vld = 1'b0;
    alu_out = '0; alu_out_vld = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_fun, clk_gate_en, tx_p_data, tx_d_vld}), 0);
    rst = 1'b0;
    send(8'hAA); send(8'h05);
    wr_q.push_back({4'h5, 8'h3C});
    send(8'h3C);
    repeat (3) @(negedge clk);
    fifo_full = 1'b1;
    send(8'hBB);
    rd_q.push_back(4'h5);
    send(8'h05);
    tx_q.push_back(8'h3C);
    rd_resp(8'h3C);
    repeat (10) @(negedge clk);
    chk("rd_held_while_full", tx_q.size(), 1);
    fifo_full = 1'b0;
    drain("rd_tx_done");
    send(8'hCC);
    wr_q.push_back({4'h0, 8'h0A});
    send(8'h0A);
    wr_q.push_back({4'h1, 8'h03});
    send(8'h03);
    chk("gate_in_alu_fun", clk_gate_en, 1);
    alu_q.push_back(4'h0);
    send(8'h00);
    tx_q.push_back(8'h0D);
    tx_q.push_back(8'h00);
    alu_resp(16'h000D);
    drain("alu_ops_tx_done");
    chk("gate_off_after_alu", clk_gate_en, 0);
    send(8'hDD);
    alu_q.push_back(4'h2);
    send(8'h02);
    send(8'h99);
    send(8'hAA);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'h12);
    alu_resp(16'h1234);
    drain("alu_noops_tx_done");
    chk("alu_fun_held", alu_fun, 4'h2);
    repeat (4) @(negedge clk);
    send(8'h55);
    repeat (4) @(negedge clk);
    send(8'hAA); send(8'h01);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midcmd_reset_outs", 32'({rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_fun, clk_gate_en, tx_p_data, tx_d_vld}), 0);
    rst = 1'b0;
    send(8'h77);
    repeat (4) @(negedge clk);
    chk("no_write_after_reset", rf_wr_data, 0);
`ifdef CMD_TIMEOUT_EN
    send(8'hCC);
    wr_q.push_back({4'h0, 8'h01});
    send(8'h01);
    repeat (20) @(negedge clk);
    send(8'hDD);
    alu_q.push_back(4'h0);
    send(8'h00);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h00);
    alu_resp(16'h00A5);
    drain("timeout_recovery_tx_done");
`endif
    repeat (4) @(negedge clk);
    chk("queues_empty", wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sys_ctrl_cmd_sequencer.md
Name: sys_ctrl_cmd_sequencer

Overview:
Command-sequencing controller in the REF_CLK domain, between the UART RX deserializer (after the enable-pulse synchronizer) and the register file, ALU and TX async FIFO.
- Decodes framed byte commands: register write, register read, ALU op with operands, ALU op without operands.
- Sequences register-file strobes, the ALU clock-gate and enable, and pushes response bytes into the TX FIFO with back-pressure.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes and register data
ADDR_WIDTH, 4, register-file address width
ALU_OUT_WIDTH, 16, ALU result width; sent as two bytes, low byte first
TIMEOUT_CYCLES, 4096, inter-byte timeout in REF_CLK cycles; used only with CMD_TIMEOUT_EN

Ports:
REF_CLK  input  1  system clock; all logic rising-edge
RST  input  1  synchronous active-high reset
RX_P_DATA  input  DATA_WIDTH  received byte; valid when RX_D_VLD=1
RX_D_VLD  input  1  one-cycle byte-valid pulse (synchronized)
RF_RD_DATA  input  DATA_WIDTH  register-file read data
RF_RD_DATA_VLD  input  1  read data valid, one cycle, arrives at least 1 cycle after RF_RD_EN
ALU_OUT  input  ALU_OUT_WIDTH  ALU result
ALU_OUT_VLD  input  1  ALU result valid, one cycle
FIFO_FULL  input  1  TX FIFO full
RF_ADDR  output  ADDR_WIDTH  register-file address
RF_WR_EN  output  1  write strobe, one cycle
RF_RD_EN  output  1  read strobe, one cycle
RF_WR_DATA  output  DATA_WIDTH  write data
ALU_EN  output  1  ALU start, one cycle
ALU_FUN  output  4  ALU function code
CLK_GATE_EN  output  1  ALU clock-gate enable
TX_P_DATA  output  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  output  1  FIFO write increment, one cycle

Behaviour:
- Clocking and reset: one clock, REF_CLK. RST is synchronous and active-high.
- Outputs: all registered. On RST, every output is 0, FSM goes to IDLE and latched address/data are cleared.
- RST mid-command aborts it: no further strobes, and no partial response is sent.
- Opcodes, checked only in IDLE:
  - 0xAA = write (addr, data)
  - 0xBB = read (addr)
  - 0xCC = ALU (A, B, fun)
  - 0xDD = ALU (fun)
  - Any other byte in IDLE is ignored; FSM stays in IDLE.
- Register write: WR_ADDR latches RX_P_DATA[ADDR_WIDTH-1:0]. The next byte in WR_DATA produces, on the next cycle, RF_WR_EN=1 for 1 cycle with the latched RF_ADDR and RF_WR_DATA=byte; FSM → IDLE.
- Register read: the byte in RD_ADDR produces, on the next cycle, RF_RD_EN=1 for 1 cycle with RF_ADDR=addr; FSM → RD_WAIT. In RD_WAIT, RF_RD_DATA_VLD latches the data → SEND_RD.
- ALU with operands (0xCC):
  - ALU_A: byte written to RF addr 0 (RF_WR_EN pulse).
  - ALU_B: byte written to RF addr 1; FSM → ALU_FUN.
- ALU without operands (0xDD): IDLE → ALU_FUN directly.
- CLK_GATE_EN is 1 in states ALU_FUN and ALU_WAIT, so it rises at least 1 cycle before ALU_EN.
- ALU_FUN state: on a byte, ALU_FUN<=byte[3:0] and ALU_EN=1 for 1 cycle → ALU_WAIT.
- ALU_WAIT: ALU_OUT_VLD latches the result → SEND_LO. CLK_GATE_EN falls on leaving ALU_WAIT. ALU_FUN holds its value until the next ALU command.
- SEND_RD, SEND_LO, SEND_HI:
  - While FIFO_FULL=1, hold state with TX_D_VLD=0.
  - When FIFO_FULL=0, TX_D_VLD=1 for 1 cycle with TX_P_DATA = the byte, then advance: SEND_RD→IDLE, SEND_LO→SEND_HI (result[7:0]), SEND_HI→IDLE (result[15:8]).
  - TX_P_DATA is stable for the duration of its TX_D_VLD pulse.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT or any SEND state: the byte is dropped and the FSM is unaffected.
- RX_D_VLD coinciding with the transition into IDLE: evaluated next cycle only, so that byte is dropped.
- Strobes never overlap: RF_WR_EN, RF_RD_EN and ALU_EN are mutually exclusive.

Optional Feature:
CMD_TIMEOUT_EN
- Defined: in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B and ALU_FUN, a counter counts REF_CLK cycles since the last accepted byte and reloads on each RX_D_VLD.
  - On reaching TIMEOUT_CYCLES, the FSM returns to IDLE with no strobes.
  - CLK_GATE_EN drops if it was set.
  - Wait and send states are not timed.
- Undefined: no counter; the FSM waits indefinitely for the next byte.

Test Plan:
- Write: RX 0xAA, 0x05, 0x3C → one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x3C; FSM back to IDLE.
- Read with back-pressure: RX 0xBB, 0x05; RF returns 0x3C; FIFO_FULL=1 for 10 cycles → no TX_D_VLD while full, then exactly one TX_D_VLD with TX_P_DATA=0x3C.
- ALU with operands: RX 0xCC, 0x0A, 0x03, 0x00; ALU_OUT=0x000D → RF writes addr0=0x0A and addr1=0x03; CLK_GATE_EN high ≥1 cycle before ALU_EN; ALU_FUN=0; TX bytes 0x0D then 0x00.
- ALU without operands: RX 0xDD, 0x02; ALU_OUT=0x1234 → ALU_FUN=2; TX 0x34 then 0x12; RX bytes sent during ALU_WAIT are ignored.
- Illegal opcode and reset: RX 0x55 → no strobes. RX 0xAA, 0x01, then RST before the data byte → all outputs 0, and a following 0x77 byte does not write.
- Timeout (with CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): RX 0xCC, 0x01, then idle 16 cycles → IDLE; later RX 0xDD, 0x00 behaves normally.
